alu_rr_scheduler: RTL and testbench

ALU_RR_SCHEDULER -- requirements
Module: alu_rr_scheduler

---
 rtl/alu_rr_scheduler.sv | 152 +++++++++++++++
 tb/tb_alu_rr_scheduler.sv | 203 ++++++++++++++++++++
 2 files changed

// File: rtl/alu_rr_scheduler.sv
// alu_rr_scheduler
//   Shares a single 8-bit ALU among N_REQ requesters. A round-robin arbiter
//   grants one requester from IDLE, its operands are captured, the result is
//   computed in EXEC and presented in RESP until the consumer accepts it.
//
// Ports
//   clk         clock, all state updates on the rising edge
//   rst         synchronous active-high reset
//   req_valid   per-requester request
//   req_ready   per-requester accept (one-hot or zero, combinational in IDLE)
//   req_a/req_b operands, requester i at [8i+7:8i]
//   req_op      opcode, requester i at [2i+1:2i] (00 add, 01 sub, 10 and, 11 or)
//   rsp_valid   result available
//   rsp_ready   consumer accepts result
//   rsp_id      index of the requester owning the result
//   rsp_result  8-bit ALU result
//   rsp_zero    rsp_result == 0
//   busy        FSM not in IDLE
module alu_rr_scheduler #(
  parameter int unsigned N_REQ = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [N_REQ-1:0]           req_valid,
  output logic [N_REQ-1:0]           req_ready,
  input  logic [8*N_REQ-1:0]         req_a,
  input  logic [8*N_REQ-1:0]         req_b,
  input  logic [2*N_REQ-1:0]         req_op,
  output logic                       rsp_valid,
  input  logic                       rsp_ready,
  output logic [$clog2(N_REQ)-1:0]   rsp_id,
  output logic [7:0]                 rsp_result,
  output logic                       rsp_zero,
  output logic                       busy
);

  localparam int unsigned IW = $clog2(N_REQ);

  typedef enum logic [1:0] {S_IDLE, S_EXEC, S_RESP} state_t;

  state_t          state_q;
  logic [IW-1:0]   ptr_q;
  logic [7:0]      a_q, b_q;
  logic [1:0]      op_q;
  logic [IW-1:0]   id_q;
  logic            rsp_valid_q;
  logic [7:0]      rsp_result_q;
  logic            rsp_zero_q;
  logic [IW-1:0]   rsp_id_q;

  // Arbiter outputs
  logic            grant_vld;
  logic [IW-1:0]   grant_idx;
  logic [IW-1:0]   ptr_d;
  logic [7:0]      sel_a, sel_b;
  logic [1:0]      sel_op;
  int unsigned     scan_int;
  int unsigned     next_int;
  logic [IW-1:0]   scan_idx;

  logic [7:0]      result_d;

  // Scan from ptr upward with wrap; the first valid requester wins and its
  // operands are muxed out alongside the grant.
  always_comb begin
    grant_vld = 1'b0;
    grant_idx = '0;
    ptr_d     = ptr_q;
    sel_a     = '0;
    sel_b     = '0;
    sel_op    = '0;
    scan_int  = 0;
    next_int  = 0;
    scan_idx  = '0;
    for (int unsigned k = 0; k < N_REQ; k++) begin
      scan_int = 32'(ptr_q) + k;
      if (scan_int >= N_REQ) scan_int = scan_int - N_REQ;
      scan_idx = IW'(scan_int);
      if (!grant_vld && req_valid[scan_idx]) begin
        grant_vld = 1'b1;
        grant_idx = scan_idx;
        next_int  = (scan_int + 1 == N_REQ) ? 0 : scan_int + 1;
        ptr_d     = IW'(next_int);
        sel_a     = 8'(req_a  >> (8 * scan_int));
        sel_b     = 8'(req_b  >> (8 * scan_int));
        sel_op    = 2'(req_op >> (2 * scan_int));
      end
    end
  end

  always_comb begin
    result_d = '0;
    case (op_q)
      2'b00: result_d = a_q + b_q;
      2'b01: result_d = a_q - b_q;
      2'b10: result_d = a_q & b_q;
      2'b11: result_d = a_q | b_q;
      default: result_d = '0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= S_IDLE;
      ptr_q        <= '0;
      a_q          <= '0;
      b_q          <= '0;
      op_q         <= '0;
      id_q         <= '0;
      rsp_valid_q  <= 1'b0;
      rsp_result_q <= '0;
      rsp_zero_q   <= 1'b0;
      rsp_id_q     <= '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (grant_vld) begin
            a_q     <= sel_a;
            b_q     <= sel_b;
            op_q    <= sel_op;
            id_q    <= grant_idx;
            ptr_q   <= ptr_d;
            state_q <= S_EXEC;
          end
        end
        S_EXEC: begin
          rsp_result_q <= result_d;
          rsp_zero_q   <= (result_d == 8'h00);
          rsp_id_q     <= id_q;
          rsp_valid_q  <= 1'b1;
          state_q      <= S_RESP;
        end
        S_RESP: begin
          if (rsp_ready) begin
            rsp_valid_q <= 1'b0;
            state_q     <= S_IDLE;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign req_ready  = (state_q == S_IDLE && !rst && grant_vld) ?
                      (N_REQ'(1) << grant_idx) : '0;
  assign rsp_valid  = rsp_valid_q;
  assign rsp_result = rsp_result_q;
  assign rsp_zero   = rsp_zero_q;
  assign rsp_id     = rsp_id_q;
  assign busy       = (state_q != S_IDLE);

endmodule

// File: tb/tb_alu_rr_scheduler.sv
// tb_alu_rr_scheduler
//   Directed bench for alu_rr_scheduler (N_REQ = 4). Inputs are driven and
//   outputs sampled 1-2 time units after each rising edge.
module tb_alu_rr_scheduler;

  logic        clk;
  logic        rst;
  logic [3:0]  req_valid;
  logic [3:0]  req_ready;
  logic [31:0] req_a;
  logic [31:0] req_b;
  logic [7:0]  req_op;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [1:0]  rsp_id;
  logic [7:0]  rsp_result;
  logic        rsp_zero;
  logic        busy;

  int checks = 0;
  int errors = 0;

  alu_rr_scheduler #(.N_REQ(4)) dut (
    .clk        (clk),
    .rst        (rst),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_a      (req_a),
    .req_b      (req_b),
    .req_op     (req_op),
    .rsp_valid  (rsp_valid),
    .rsp_ready  (rsp_ready),
    .rsp_id     (rsp_id),
    .rsp_result (rsp_result),
    .rsp_zero   (rsp_zero),
    .busy       (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, errors so far %0d", errors);
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(input int i, input logic [7:0] a, input logic [7:0] b,
                         input logic [1:0] op);
    req_a[8*i +: 8]  = a;
    req_b[8*i +: 8]  = b;
    req_op[2*i +: 2] = op;
  endtask

  // One isolated operation from requester idx with rsp_ready held high.
  task automatic do_op(input int idx, input logic [7:0] a, input logic [7:0] b,
                       input logic [1:0] op, input logic [7:0] exp);
    set_req(idx, a, b, op);
    req_valid = 4'(1 << idx);
    #1;
    check("op_grant", 32'(req_ready), 32'(1 << idx));
    step();
    req_valid = 4'b0000;
    #1;
    check("op_exec_busy", 32'(busy), 32'd1);
    check("op_exec_nvalid", 32'(rsp_valid), 32'd0);
    check("op_exec_nready", 32'(req_ready), 32'd0);
    step();
    check("op_rsp_valid", 32'(rsp_valid), 32'd1);
    check("op_rsp_id", 32'(rsp_id), 32'(idx));
    check("op_rsp_result", 32'(rsp_result), 32'(exp));
    check("op_rsp_zero", 32'(rsp_zero), 32'(exp == 8'h00));
    step();
    check("op_idle_nvalid", 32'(rsp_valid), 32'd0);
    check("op_idle_nbusy", 32'(busy), 32'd0);
    check("op_idle_hold", 32'(rsp_result), 32'(exp));
  endtask

  initial begin
    rst       = 1'b1;
    req_valid = '0;
    req_a     = '0;
    req_b     = '0;
    req_op    = '0;
    rsp_ready = 1'b1;

    // Reset state
    step();
    step();
    check("rst_valid", 32'(rsp_valid), 32'd0);
    check("rst_result", 32'(rsp_result), 32'h00);
    check("rst_zero", 32'(rsp_zero), 32'd0);
    check("rst_id", 32'(rsp_id), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    req_valid = 4'b1111;
    #1;
    check("rst_nready", 32'(req_ready), 32'd0);
    req_valid = 4'b0000;
    rst = 1'b0;
    step();

    // Single subtract, then wrap/logic cases across requesters
    do_op(0, 8'h3C, 8'h05, 2'b01, 8'h37);
    do_op(1, 8'hFF, 8'h01, 2'b00, 8'h00);
    do_op(2, 8'h00, 8'h01, 2'b01, 8'hFF);
    do_op(3, 8'hF0, 8'h0F, 2'b10, 8'h00);
    do_op(0, 8'hF0, 8'h0F, 2'b11, 8'hFF);
    do_op(3, 8'h12, 8'h34, 2'b00, 8'h46);   // leaves ptr at 0

    // Fairness: all four held high, expected order 0,1,2,3,0
    for (int i = 0; i < 4; i++) set_req(i, 8'(8'h10 * (i + 1)), 8'(i + 1), 2'b00);
    req_valid = 4'b1111;
    for (int g = 0; g < 5; g++) begin
      #1;
      check("rr_grant", 32'(req_ready), 32'(1 << (g % 4)));
      step();
      check("rr_exec_nready", 32'(req_ready), 32'd0);
      step();
      check("rr_rsp_valid", 32'(rsp_valid), 32'd1);
      check("rr_rsp_id", 32'(rsp_id), 32'(g % 4));
      check("rr_rsp_result", 32'(rsp_result), 32'(8'h11 * ((g % 4) + 1)));
      step();
    end
    req_valid = 4'b0000;                     // ptr now 1

    // Backpressure on requester 1: 0x20 - 0x07 = 0x19
    rsp_ready = 1'b0;
    set_req(1, 8'h20, 8'h07, 2'b01);
    req_valid = 4'b0010;
    #1;
    check("bp_grant", 32'(req_ready), 32'b0010);
    step();
    req_valid = 4'b1111;
    step();
    for (int c = 0; c < 5; c++) begin
      check("bp_valid", 32'(rsp_valid), 32'd1);
      check("bp_result", 32'(rsp_result), 32'h19);
      check("bp_id", 32'(rsp_id), 32'd1);
      check("bp_nready", 32'(req_ready), 32'd0);
      step();
    end
    set_req(2, 8'h10, 8'h01, 2'b00);
    rsp_ready = 1'b1;
    #1;
    check("bp_release_valid", 32'(rsp_valid), 32'd1);
    step();
    check("bp_idle_nvalid", 32'(rsp_valid), 32'd0);
    check("bp_idle_nbusy", 32'(busy), 32'd0);
    check("bp_next_grant", 32'(req_ready), 32'b0100);  // ptr 2

    // Operand hold: a2 changes after its grant
    step();
    set_req(2, 8'h99, 8'h01, 2'b00);
    req_valid = 4'b0000;
    step();
    check("hold_valid", 32'(rsp_valid), 32'd1);
    check("hold_id", 32'(rsp_id), 32'd2);
    check("hold_result", 32'(rsp_result), 32'h11);
    step();                                  // ptr now 3

    // Reset in EXEC: grant 2 (ptr becomes 3), then reset discards it
    req_valid = 4'b0100;
    #1;
    check("rm_grant", 32'(req_ready), 32'b0100);
    step();
    req_valid = 4'b0000;
    rst = 1'b1;
    step();
    check("rm_nvalid", 32'(rsp_valid), 32'd0);
    check("rm_nbusy", 32'(busy), 32'd0);
    check("rm_result", 32'(rsp_result), 32'h00);
    rst = 1'b0;
    step();
    check("rm_no_rsp", 32'(rsp_valid), 32'd0);
    req_valid = 4'b1010;
    #1;
    check("rm_grant_after", 32'(req_ready), 32'b0010);  // ptr reset to 0
    step();
    req_valid = 4'b0000;
    step();
    check("rm_op_valid", 32'(rsp_valid), 32'd1);
    check("rm_op_id", 32'(rsp_id), 32'd1);
    check("rm_op_result", 32'(rsp_result), 32'h19);
    step();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
